// File: rtl/parity_frame_pkg.sv
// rtl/parity_frame_pkg.sv - shared state type, line constants and parity helper for parity_frame_tx
package parity_frame_pkg;

  localparam int   PKG_DATA_W = 8;
  localparam int   FRAME_BITS = PKG_DATA_W + 3;
  localparam logic LINE_IDLE  = 1'b1;
  localparam logic START_LVL  = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  // Callers zero-extend narrower words; extra zeros leave the XOR unchanged.
  function automatic logic parity_of(input logic [31:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/parity_frame_baud_cnt.sv
// rtl/parity_frame_baud_cnt.sv - bit-period counter, one-cycle bit_tick on the last cycle of each bit
module parity_frame_baud_cnt #(
  parameter int BIT_CYC = 16,
  parameter int CNT_W   = 16
) (
  input  logic CK,
  input  logic RESET_N,
  input  logic clr,
  input  logic en,
  output logic bit_tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(BIT_CYC - 1);

  logic [CNT_W-1:0] cnt;

  assign bit_tick = en && (cnt == LAST);

  // Wrapping on bit_tick keeps cnt inside 0..BIT_CYC-1 at all times.
  always_ff @(posedge CK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= bit_tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/parity_frame_tx.sv
// rtl/parity_frame_tx.sv - framed serial transmitter with parity; PARITY_TX_ODD_EN selects odd parity
module parity_frame_tx #(
  parameter int DATA_W  = 8,
  parameter int BIT_CYC = 16,
  parameter int CNT_W   = 16
) (
  input  logic              CK,
  input  logic              RESET_N,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              ser_out,
  output logic              busy,
  output logic              par_bit,
  output logic              frame_done
);

  import parity_frame_pkg::*;

  localparam int               IDX_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] sreg_q, sreg_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              par_q, par_d;
  logic              ser_q, ser_d;
  logic              word_par;
  logic              accept;
  logic              bit_tick;

  assign tx_ready   = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign accept     = tx_valid && tx_ready;
  assign frame_done = (state_q == STOP) && bit_tick;
  assign ser_out    = ser_q;
  assign par_bit    = par_q;

`ifdef PARITY_TX_ODD_EN
  assign word_par = ~parity_of(32'(tx_data));
`else
  assign word_par = parity_of(32'(tx_data));
`endif

  parity_frame_baud_cnt #(
    .BIT_CYC (BIT_CYC),
    .CNT_W   (CNT_W)
  ) u_baud (
    .CK       (CK),
    .RESET_N  (RESET_N),
    .clr      (accept),
    .en       (busy),
    .bit_tick (bit_tick)
  );

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    idx_d   = idx_q;
    par_d   = par_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = START;
          sreg_d  = tx_data;
          par_d   = word_par;
          idx_d   = '0;
        end
      end
      START: begin
        if (bit_tick) state_d = DATA;
      end
      DATA: begin
        if (bit_tick) begin
          if (idx_q == IDX_LAST) begin
            state_d = PARITY;
            idx_d   = '0;
          end else begin
            idx_d  = idx_q + 1'b1;
            sreg_d = sreg_q >> 1;
          end
        end
      end
      PARITY: begin
        if (bit_tick) state_d = STOP;
      end
      STOP: begin
        if (bit_tick) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level is decoded from the next state so ser_out lines up with the state register.
  always_comb begin
    ser_d = LINE_IDLE;
    case (state_d)
      START:   ser_d = START_LVL;
      DATA:    ser_d = sreg_d[0];
      PARITY:  ser_d = par_d;
      default: ser_d = LINE_IDLE;
    endcase
  end

  always_ff @(posedge CK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      idx_q   <= '0;
      par_q   <= 1'b0;
      ser_q   <= LINE_IDLE;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      idx_q   <= idx_d;
      par_q   <= par_d;
      ser_q   <= ser_d;
    end
  end

endmodule

// File: tb/tb_parity_frame_tx.sv
// tb/tb_parity_frame_tx.sv - randomized self-checking bench for parity_frame_tx (BIT_CYC 4 and 2 instances)
module tb_parity_frame_tx;

`ifdef PARITY_TX_ODD_EN
  localparam logic ODD = 1'b1;
`else
  localparam logic ODD = 1'b0;
`endif
  localparam int BC  = 4;
  localparam int BC2 = 2;
  localparam int NSLOT = 11;

  logic       CK;
  logic       RESET_N;
  logic [7:0] tx_data, tx_data2;
  logic       tx_valid, tx_valid2;
  logic       tx_ready, tx_ready2;
  logic       ser_out, ser_out2;
  logic       busy, busy2;
  logic       par_bit, par_bit2;
  logic       frame_done, frame_done2;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc_cyc;
  int done_cyc;

  parity_frame_tx #(.DATA_W(8), .BIT_CYC(BC), .CNT_W(16)) u_dut (
    .CK(CK), .RESET_N(RESET_N), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .ser_out(ser_out), .busy(busy), .par_bit(par_bit),
    .frame_done(frame_done)
  );

  parity_frame_tx #(.DATA_W(8), .BIT_CYC(BC2), .CNT_W(16)) u_dut2 (
    .CK(CK), .RESET_N(RESET_N), .tx_data(tx_data2), .tx_valid(tx_valid2),
    .tx_ready(tx_ready2), .ser_out(ser_out2), .busy(busy2), .par_bit(par_bit2),
    .frame_done(frame_done2)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;
  always @(posedge CK) cyc <= cyc + 1;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  // Line level of a frame slot: start, data LSB first, parity, stop.
  function automatic logic exp_level(input logic [7:0] w, input logic p, input int slot);
    if (slot == 0) return 1'b0;
    if (slot <= 8) return w[slot-1];
    if (slot == 9) return p;
    return 1'b1;
  endfunction

  function automatic logic exp_parity(input logic [7:0] w);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(w[i]);
    return logic'(ones % 2) ^ ODD;
  endfunction

  task automatic wait_accept(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (tx_ready === 1'b1) begin
        acc_cyc = cyc;
        @(posedge CK);
        ok = 1'b1;
        return;
      end
      @(negedge CK);
    end
    bad++; total++;
    $display("FAIL accept_timeout: tx_ready never high within 200 cycles");
  endtask

  // mode 0: drop tx_valid; mode 1: keep valid with next word; mode 2: random disturbance.
  task automatic check_frame(input logic [7:0] w, input int mode, input logic [7:0] nxt);
    logic       p;
    logic [9:0] rx;
    int         ones;
    p  = exp_parity(w);
    rx = '0;
    @(negedge CK);
    total++;
    if (par_bit !== p) begin
      bad++; $display("FAIL par_bit word=%02h: got %b want %b", w, par_bit, p);
    end
    if (mode == 0) tx_valid = 1'b0;
    else if (mode == 1) tx_data = nxt;
    for (int k = 0; k < NSLOT*BC; k++) begin
      if (k > 0) @(negedge CK);
      total++;
      if (ser_out !== exp_level(w, p, k / BC)) begin
        bad++; $display("FAIL ser_out word=%02h cyc=%0d: got %b want %b", w, k+1, ser_out, exp_level(w, p, k / BC));
      end
      total++;
      if (frame_done !== (k == NSLOT*BC-1)) begin
        bad++; $display("FAIL frame_done word=%02h cyc=%0d: got %b want %b", w, k+1, frame_done, (k == NSLOT*BC-1));
      end
      total++;
      if (tx_ready !== 1'b0 || busy !== 1'b1) begin
        bad++; $display("FAIL ready_busy word=%02h cyc=%0d: got ready=%b busy=%b want 0/1", w, k+1, tx_ready, busy);
      end
      if (k % BC == BC/2 && k / BC >= 1 && k / BC <= 9) rx[k/BC] = ser_out;
      if (k == NSLOT*BC-1) done_cyc = cyc;
      if (mode == 2) begin
        tx_data  = 8'($urandom);
        tx_valid = 1'($urandom_range(0, 1));
      end
    end
    if (mode == 2) tx_valid = 1'b0;
    total++;
    if (rx[8:1] !== w) begin
      bad++; $display("FAIL rx_data: got %02h want %02h", rx[8:1], w);
    end
    ones = 0;
    for (int i = 1; i <= 9; i++) ones += int'(rx[i]);
    total++;
    if (logic'(ones % 2) !== ODD) begin
      bad++; $display("FAIL rx_xor9 word=%02h: got %0d want %b", w, ones % 2, ODD);
    end
  endtask

  task automatic check_gap();
    @(negedge CK);
    total++;
    if (ser_out !== 1'b1 || tx_ready !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) begin
      bad++;
      $display("FAIL idle_gap: got ser=%b ready=%b busy=%b done=%b want 1/1/0/0", ser_out, tx_ready, busy, frame_done);
    end
  endtask

  task automatic send_one(input logic [7:0] w, input int mode);
    bit ok;
    tx_data  = w;
    tx_valid = 1'b1;
    wait_accept(ok);
    if (!ok) begin
      tx_valid = 1'b0;
      return;
    end
    check_frame(w, mode, 8'h00);
    check_gap();
  endtask

  task automatic test_reset();
    RESET_N  = 1'b0;
    tx_valid = 1'b0; tx_data = 8'h00;
    tx_valid2 = 1'b0; tx_data2 = 8'h00;
    repeat (3) @(negedge CK);
    total++;
    if (ser_out !== 1'b1 || tx_ready !== 1'b1 || busy !== 1'b0 || par_bit !== 1'b0 || frame_done !== 1'b0) begin
      bad++;
      $display("FAIL reset_values: got ser=%b ready=%b busy=%b par=%b done=%b want 1/1/0/0/0", ser_out, tx_ready, busy, par_bit, frame_done);
    end
    RESET_N = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge CK);
      total++;
      if (ser_out !== 1'b1 || tx_ready !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) begin
        bad++;
        $display("FAIL idle_after_reset cyc=%0d: got ser=%b ready=%b busy=%b done=%b want 1/1/0/0", i, ser_out, tx_ready, busy, frame_done);
      end
    end
  endtask

  task automatic test_a5();
    send_one(8'hA5, 0);
    total++;
    if (done_cyc - acc_cyc !== NSLOT*BC) begin
      bad++; $display("FAIL a5_latency: got %0d want %0d", done_cyc - acc_cyc, NSLOT*BC);
    end
  endtask

  task automatic test_parity();
    send_one(8'h07, 0);
    send_one(8'h00, 0);
    send_one(8'h01, 0);
  endtask

  task automatic test_back_to_back();
    bit ok;
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    wait_accept(ok);
    if (!ok) begin
      tx_valid = 1'b0;
      return;
    end
    check_frame(8'h00, 1, 8'hFF);
    check_gap();
    wait_accept(ok);
    if (!ok) begin
      tx_valid = 1'b0;
      return;
    end
    total++;
    if (acc_cyc - done_cyc !== 1) begin
      bad++; $display("FAIL b2b_gap: got %0d cycles want 1", acc_cyc - done_cyc);
    end
    check_frame(8'hFF, 0, 8'h00);
    check_gap();
  endtask

  task automatic test_disturb();
    for (int i = 0; i < 3; i++) send_one(8'($urandom), 2);
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) send_one(8'($urandom), 0);
  endtask

  task automatic run_bc2(input logic [7:0] w);
    logic p;
    bit   ok;
    p = exp_parity(w);
    ok = 1'b0;
    tx_data2  = w;
    tx_valid2 = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (tx_ready2 === 1'b1) ok = 1'b1;
      else @(negedge CK);
    end
    if (!ok) begin
      bad++; total++;
      $display("FAIL bc2_accept_timeout: tx_ready2 never high");
      tx_valid2 = 1'b0;
      return;
    end
    @(posedge CK);
    @(negedge CK);
    tx_valid2 = 1'b0;
    for (int k = 0; k < NSLOT*BC2; k++) begin
      if (k > 0) @(negedge CK);
      total++;
      if (ser_out2 !== exp_level(w, p, k / BC2)) begin
        bad++; $display("FAIL bc2_ser_out word=%02h cyc=%0d: got %b want %b", w, k+1, ser_out2, exp_level(w, p, k / BC2));
      end
      total++;
      if (frame_done2 !== (k == NSLOT*BC2-1)) begin
        bad++; $display("FAIL bc2_frame_done word=%02h cyc=%0d: got %b want %b", w, k+1, frame_done2, (k == NSLOT*BC2-1));
      end
      total++;
      if (u_dut2.u_baud.cnt > 16'(BC2-1)) begin
        bad++; $display("FAIL bc2_cnt_range cyc=%0d: got %0d want <= %0d", k+1, u_dut2.u_baud.cnt, BC2-1);
      end
    end
    @(negedge CK);
    total++;
    if (ser_out2 !== 1'b1 || busy2 !== 1'b0 || tx_ready2 !== 1'b1) begin
      bad++; $display("FAIL bc2_end: got ser=%b busy=%b ready=%b want 1/0/1", ser_out2, busy2, tx_ready2);
    end
  endtask

  task automatic test_bitcyc2();
    run_bc2(8'h80);
    run_bc2(8'($urandom));
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    tx_data  = 8'($urandom);
    tx_valid = 1'b1;
    wait_accept(ok);
    if (!ok) begin
      tx_valid = 1'b0;
      return;
    end
    @(negedge CK);
    tx_valid = 1'b0;
    total++;
    if (ser_out !== 1'b0) begin
      bad++; $display("FAIL mid_start_line: got %b want 0", ser_out);
    end
    @(negedge CK);
    RESET_N = 1'b0;
    #1;
    total++;
    if (ser_out !== 1'b1 || busy !== 1'b0 || tx_ready !== 1'b1 || frame_done !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_frame: got ser=%b busy=%b ready=%b done=%b want 1/0/1/0", ser_out, busy, tx_ready, frame_done);
    end
    @(negedge CK);
    RESET_N = 1'b1;
    for (int i = 0; i < 3*NSLOT*BC; i++) begin
      @(negedge CK);
      total++;
      if (frame_done !== 1'b0 || ser_out !== 1'b1) begin
        bad++; $display("FAIL after_abort cyc=%0d: got done=%b ser=%b want 0/1", i, frame_done, ser_out);
      end
    end
  endtask

  initial begin
    RESET_N   = 1'b0;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    tx_valid2 = 1'b0;
    tx_data2  = 8'h00;
    test_reset();
    test_a5();
    test_parity();
    test_back_to_back();
    test_disturb();
    test_random();
    test_bitcyc2();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/parity_frame_tx.md
Name: parity_frame_tx

Overview:
- Serial transmitter for parity-protected 8-bit words.
- Generates an even parity bit over the data byte, so the receiving checker's 9-input XOR over data+parity evaluates to 0 on a good frame.
- Frames each word as start, 8 data bits LSB first, parity, stop; shifts it out at a programmable bit period.
- Sits upstream of the existing combinational 9-bit parity checker; it is the sending end of the same link.

Parameters:
- DATA_W, 8: payload width in bits (parity always covers DATA_W bits).
- BIT_CYC, 16: clock cycles per serial bit; legal range 2..65535.
- CNT_W, 16: width of the bit-period counter; must satisfy 2^CNT_W > BIT_CYC.

Ports:
- CK  input  1  clock, all state updates on rising edge.
- RESET_N  input  1  asynchronous active-low reset.
- tx_data  input  DATA_W  word to send, sampled on accept.
- tx_valid  input  1  word available.
- tx_ready  output  1  block can accept a word this cycle.
- ser_out  output  1  serial line, idle high.
- busy  output  1  frame in progress.
- par_bit  output  1  parity bit of the word currently being sent (debug/observe).
- frame_done  output  1  one-cycle pulse at end of stop bit.

Behaviour:
- Reset is asynchronous and active-low on RESET_N, clocked on CK, single clock domain.
- Reset values: ser_out=1, tx_ready=1, busy=0, par_bit=0, frame_done=0, state=IDLE, counters=0.
- Handshake: a word is accepted when tx_valid && tx_ready at a rising edge.
  - tx_data and parity = XOR of all tx_data bits are latched into a shift register in the same edge.
  - tx_ready is low from the accept cycle until the cycle after frame_done; tx_ready is combinationally (state==IDLE).
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on accept.
  - START -> DATA after BIT_CYC cycles.
  - DATA holds for DATA_W bit periods, shifting LSB first; bit index counts 0..DATA_W-1, then -> PARITY.
  - PARITY -> STOP after BIT_CYC cycles.
  - STOP -> IDLE after BIT_CYC cycles, with frame_done=1 in the last STOP cycle.
- ser_out is registered: 0 in START, data bit in DATA, par_bit in PARITY, 1 in STOP and IDLE.
- Latency: ser_out falls one cycle after the accept edge. Total frame = (DATA_W+3)*BIT_CYC cycles.
- Bit counter runs 0..BIT_CYC-1, wraps to 0 on each bit boundary, and never exceeds BIT_CYC-1.
- Back-to-back: tx_valid held high with a new word is accepted in the IDLE cycle following STOP; minimum one idle-high cycle between frames.
- tx_data changes while busy: ignored.
- tx_valid deasserted mid-frame: no effect.
- Reset mid-frame: line returns to 1 immediately (asynchronous); the frame is aborted and no frame_done pulse is issued.
- busy = (state != IDLE).

Optional Feature:
- PARITY_TX_ODD_EN defined: par_bit = ~XOR(tx_data), so the data+parity 9-bit XOR = 1 (odd parity).
- Undefined (default): even parity as above.
- Frame format and timing are identical in both builds.

Decomposition:
- Shared package parity_frame_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - constants FRAME_BITS = DATA_W+3, LINE_IDLE = 1'b1, START_LVL = 1'b0;
  - a function parity_of(word) returning the XOR reduction.
- One sub-module is natural: parity_frame_baud_cnt, the bit-period counter emitting a one-cycle bit_tick at count BIT_CYC-1, cleared on accept.
- FSM and shifter stay in the top module.

Test Plan:
- Reset then idle 50 cycles -> ser_out=1, tx_ready=1, busy=0 throughout; assert RESET_N low mid-START -> ser_out=1 that cycle, state IDLE, no frame_done.
- Send 0xA5 with BIT_CYC=4 -> line 0, then bits 1,0,1,0,0,1,0,1, par_bit=0, stop 1; each level held exactly 4 cycles; frame_done at cycle 44 after accept.
- Send 0x07 -> par_bit=1; the 9-bit XOR of the received data+parity bits = 0. With PARITY_TX_ODD_EN: par_bit=0, XOR = 1.
- Hold tx_valid high with words 0x00 then 0xFF -> second accept exactly one cycle after first frame_done; parity bits 0 and 0; ser_out high for exactly one cycle between frames.
- Change tx_data and toggle tx_valid during a frame -> transmitted bits match the originally accepted word; tx_ready stays 0 until frame end.
- BIT_CYC=2 corner: send 0x80 -> 22-cycle frame, MSB appears in 9th bit slot, no counter overrun.
